// File: rtl/uart_pkg.sv
// uart_pkg: baud divisor table, receiver FSM states and FIFO word layout shared by the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_word_t;

  localparam int WORD_W = $bits(rx_word_t);

  function automatic int baud_rate(input logic [3:0] sel);
    case (sel)
      4'd0:    return 300;
      4'd1:    return 1200;
      4'd2:    return 2400;
      4'd3:    return 4800;
      4'd4:    return 9600;
      4'd5:    return 19200;
      4'd6:    return 38400;
      4'd7:    return 57600;
      4'd8:    return 115200;
      4'd9:    return 230400;
      4'd10:   return 460800;
      default: return 921600;
    endcase
  endfunction

  function automatic int baud_div(input int clk_hz, input logic [3:0] sel);
    return (clk_hz + baud_rate(sel) / 2) / baud_rate(sel);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, head read combinationally; a push into a full FIFO is kept only when a pop frees a slot in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];
  // Storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(do_push);
      rptr  <= rptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with mid-bit sampling, per-word parity/framing flags, sticky overrun and a ready/valid receive FIFO.
// Define UART_RX_BREAK_DETECT_EN to drop all-zero break frames and pulse brk instead of queueing them.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  baud_value,
  input  logic                        EIGHT,
  input  logic                        PEN,
  input  logic                        OHEL,
  input  logic                        RX,
  output logic [7:0]                  rx_data,
  output logic                        rx_perr,
  output logic                        rx_ferr,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        ovf,
  input  logic                        ovf_clr,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic                        brk,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CW = $clog2(baud_div(CLK_HZ, 4'd0) + 1);
  rx_state_t              state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_prev, start_edge, tick, last_bit, stop_tick;
  logic [CW-1:0]          div_tab [16];
  logic [CW-1:0]          div_q, cnt;
  logic [2:0]             bcnt;
  logic [7:0]             data;
  logic                   eight_q, pen_q, ohel_q, perr_q, ferr_q;
  logic                   push, pop, full, empty;
  rx_word_t               head;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                   par_q, brk_wait, is_break;
  assign is_break = data == 8'd0 && !par_q && !rx_s;
`endif

  for (genvar i = 0; i < 16; i++) begin : g_div
    assign div_tab[i] = CW'(baud_div(CLK_HZ, 4'(i)));
  end

  assign rx_s       = sync[SYNC_STAGES-1];
  assign start_edge = rx_prev && !rx_s;
  assign tick       = (state == START) ? (cnt == (div_q >> 1)) : (cnt == div_q - 1'b1);
  assign last_bit   = bcnt == (eight_q ? 3'd7 : 3'd6);
  assign stop_tick  = state == STOP && tick;
  assign pop        = rx_valid && rx_ready;
  assign rx_valid   = !empty;
  assign rx_data    = head.data;
  assign rx_perr    = head.perr;
  assign rx_ferr    = head.ferr;

  // RX synchroniser plus previous sample; both reset high so reset never fakes a start edge
  always_ff @(posedge clk)
    if (reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], RX};
      rx_prev <= rx_s;
    end

  // State register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;

  // Next state: start edge, half-bit start confirmation, then one sample per bit period
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_edge ? START : IDLE;
      START:   state_n = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = (tick && last_bit) ? (pen_q ? PARITY : STOP) : DATA;
      PARITY:  state_n = tick ? STOP : PARITY;
`ifdef UART_RX_BREAK_DETECT_EN
      STOP:    state_n = brk_wait ? (rx_s ? IDLE : STOP) : ((tick && !is_break) ? IDLE : STOP);
`else
      STOP:    state_n = tick ? IDLE : STOP;
`endif
      default: state_n = IDLE;
    endcase
  end

  // Bit timing, frame config latch and word assembly; push fires the cycle after the stop sample
  always_ff @(posedge clk)
    if (reset) begin
      cnt      <= '0;
      div_q    <= '0;
      bcnt     <= '0;
      data     <= '0;
      eight_q  <= 1'b0;
      pen_q    <= 1'b0;
      ohel_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      push     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      par_q    <= 1'b0;
      brk_wait <= 1'b0;
      brk      <= 1'b0;
`endif
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
      push     <= stop_tick && !brk_wait && !is_break;
      brk      <= stop_tick && !brk_wait && is_break;
      brk_wait <= state == STOP && (brk_wait ? !rx_s : stop_tick && is_break);
      if (state == PARITY && tick) par_q <= rx_s;
      if (state == IDLE && start_edge) par_q <= 1'b0;
`else
      push <= stop_tick;
`endif
      if (state == IDLE && start_edge) begin
        div_q   <= div_tab[baud_value];
        eight_q <= EIGHT;
        pen_q   <= PEN;
        ohel_q  <= OHEL;
        bcnt    <= '0;
        data    <= '0;
        perr_q  <= 1'b0;
      end
      if (state == DATA && tick) begin
        data[bcnt] <= rx_s;
        bcnt       <= bcnt + 1'b1;
      end
      if (state == PARITY && tick) perr_q <= (^data ^ rx_s) != ohel_q;
      if (stop_tick) ferr_q <= !rx_s;
    end

  // Sticky overrun: a word arriving while full with no pop is lost; set beats clear
  always_ff @(posedge clk)
    ovf <= reset ? 1'b0 : (push && full && !pop) || (ovf && !ovf_clr);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({ferr_q, perr_q, data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table of directed frames plus false-start, overrun and mid-frame reset sequences
module tb_uart_rx_fifo;
  localparam int CLK_HZ = 14745600;
  localparam int DEPTH  = 4;
  localparam int DIV    = 128;

  typedef struct {
    logic [3:0] bv;
    logic       eight, pen, ohel;
    logic [7:0] d;
    logic       par, stop;
    logic [7:0] xd;
    logic       xp, xf;
    int         div;
  } vec_t;

  logic       clk = 1'b0, reset = 1'b1, EIGHT = 1'b1, PEN = 1'b0, OHEL = 1'b0, RX = 1'b1;
  logic       rx_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] baud_value = 4'd8;
  logic [7:0] rx_data;
  logic       rx_perr, rx_ferr, rx_valid, ovf;
  logic [2:0] fifo_count;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ      (CLK_HZ),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_value (baud_value),
    .EIGHT      (EIGHT),
    .PEN        (PEN),
    .OHEL       (OHEL),
    .RX         (RX),
    .rx_data    (rx_data),
    .rx_perr    (rx_perr),
    .rx_ferr    (rx_ferr),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One serial bit, entered and left on a falling clock edge; optional one-cycle pulses on rx_ready / ovf_clr
  task automatic drive_bit(input logic v, input int div, input int pop_at, input int clr_at, input bit lat);
    RX = v;
    for (int j = 0; j < div; j++) begin
      rx_ready = (j == pop_at) ? 1'b1 : (j == pop_at + 1) ? 1'b0 : rx_ready;
      ovf_clr  = (j == clr_at);
      if (lat && j == div / 2) check("valid_early", rx_valid, 1'b0);
      @(negedge clk);
    end
    if (lat) check("valid_after_stop", rx_valid, 1'b1);
  endtask

  // Full frame; config is inverted after the start bit to show it was latched at start detection
  task automatic send_frame(input vec_t v, input int pop_at, input int clr_at, input bit lat);
    baud_value = v.bv;
    EIGHT      = v.eight;
    PEN        = v.pen;
    OHEL       = v.ohel;
    drive_bit(1'b0, v.div, -2, -2, 1'b0);
    baud_value = ~v.bv;
    EIGHT      = ~v.eight;
    PEN        = ~v.pen;
    OHEL       = ~v.ohel;
    for (int i = 0; i < (v.eight ? 8 : 7); i++) drive_bit(v.d[i], v.div, -2, -2, 1'b0);
    if (v.pen) drive_bit(v.par, v.div, -2, -2, 1'b0);
    drive_bit(v.stop, v.div, pop_at, clr_at, lat);
    RX = 1'b1;
    repeat (v.div) @(negedge clk);
  endtask

  task automatic pop_check(input string nm, input logic [7:0] xd, input logic xp, input logic xf);
    check({nm, "_valid"}, rx_valid, 1'b1);
    check({nm, "_data"}, rx_data, xd);
    check({nm, "_perr"}, rx_perr, xp);
    check({nm, "_ferr"}, rx_ferr, xf);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_valid"}, rx_valid, 1'b0);
    check({nm, "_data"}, rx_data, 8'h00);
    check({nm, "_perr"}, rx_perr, 1'b0);
    check({nm, "_ferr"}, rx_ferr, 1'b0);
    check({nm, "_ovf"}, ovf, 1'b0);
    check({nm, "_count"}, fifo_count, 3'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete, CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    vec_t ov;
    vecs[0] = '{4'd8,  1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, DIV};
    vecs[1] = '{4'd8,  1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, DIV};
    vecs[2] = '{4'd8,  1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, DIV};
    vecs[3] = '{4'd8,  1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, DIV};
    vecs[4] = '{4'd8,  1'b1, 1'b1, 1'b0, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0, DIV};
    vecs[5] = '{4'd8,  1'b1, 1'b1, 1'b0, 8'h96, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0, DIV};
    vecs[6] = '{4'd8,  1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, DIV};
    vecs[7] = '{4'd15, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 16};
    vecs[8] = '{4'd8,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, DIV};
    vecs[9] = '{4'd12, 1'b1, 1'b1, 1'b1, 8'hC8, 1'b0, 1'b1, 8'hC8, 1'b0, 1'b0, 16};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("reset");
    RX = 1'b0;
    repeat (40) @(negedge clk);
    RX = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("false_start_count", fifo_count, 3'd0);
    check("false_start_valid", rx_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i], -2, -2, 1'b1);
      pop_check($sformatf("v%0d", i), vecs[i].xd, vecs[i].xp, vecs[i].xf);
      check($sformatf("v%0d_popped", i), rx_valid, 1'b0);
    end
    ov = vecs[0];
    for (int i = 0; i < 4; i++) begin
      ov.d = 8'h11 + 8'(i);
      send_frame(ov, -2, -2, 1'b0);
    end
    check("fill_count", fifo_count, 3'd4);
    check("fill_ovf", ovf, 1'b0);
    ov.d = 8'h15;
    send_frame(ov, -2, DIV / 2 + 4, 1'b0);
    check("overrun_ovf_set_wins", ovf, 1'b1);
    check("overrun_count", fifo_count, 3'd4);
    check("overrun_head", rx_data, 8'h11);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 1'b0);
    ov.d = 8'h16;
    send_frame(ov, DIV / 2 + 4, -2, 1'b0);
    check("full_push_pop_count", fifo_count, 3'd4);
    check("full_push_pop_ovf", ovf, 1'b0);
    pop_check("drain0", 8'h12, 1'b0, 1'b0);
    pop_check("drain1", 8'h13, 1'b0, 1'b0);
    pop_check("drain2", 8'h14, 1'b0, 1'b0);
    pop_check("drain3", 8'h16, 1'b0, 1'b0);
    check("drained_count", fifo_count, 3'd0);
    ov.d = 8'h77;
    send_frame(ov, -2, -2, 1'b1);
    check("pre_reset_count", fifo_count, 3'd1);
    baud_value = 4'd8;
    EIGHT      = 1'b1;
    PEN        = 1'b0;
    drive_bit(1'b0, DIV, -2, -2, 1'b0);
    drive_bit(1'b1, DIV, -2, -2, 1'b0);
    drive_bit(1'b1, DIV, -2, -2, 1'b0);
    drive_bit(1'b0, DIV, -2, -2, 1'b0);
    RX = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    reset = 1'b1;
    RX    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("midframe_reset");
    repeat (3 * DIV) @(negedge clk);
    check("abandoned_frame_count", fifo_count, 3'd0);
    ov.d = 8'hC3;
    send_frame(ov, -2, -2, 1'b1);
    pop_check("after_reset", 8'hC3, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with an on-chip receive FIFO; next-generation receive path of the UART core.
- Adds mid-bit sampling with false-start rejection, per-word parity and framing flags, sticky overrun, and a ready/valid consumer interface.
- Sits between the pad-buffered RX pin and the consumer (LED/register logic or a future bus bridge); configured by the same baud_value / EIGHT / PEN / OHEL controls as the existing UART.

Parameters:
- CLK_HZ, 100000000, system clock frequency; sets the baud divisors.
- FIFO_DEPTH, 16, receive FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, RX synchroniser flops; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- baud_value  in  4  baud select
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits
- PEN  in  1  parity enable
- OHEL  in  1  1 = odd parity, 0 = even parity
- RX  in  1  serial input, asynchronous, idles high
- rx_data  out  8  FIFO head data; bit 7 = 0 in 7-bit mode
- rx_perr  out  1  FIFO head parity-error flag
- rx_ferr  out  1  FIFO head framing-error flag
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready
- ovf  out  1  sticky overrun flag
- ovf_clr  in  1  clears ovf
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - Outputs: rx_valid = 0, rx_data = 0, rx_perr = 0, rx_ferr = 0, ovf = 0, fifo_count = 0.
  - Internal: FSM in IDLE; synchroniser flops = 1.
- Reset mid-frame abandons the frame; no FIFO push.
- Baud table, divisor = round(CLK_HZ / baud). baud_value 0..11 selects 300, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; values 12..15 select 921600.
- Bit counter counts 0..div-1; half-bit point is div/2 (truncated).
- Config latch: baud_value, EIGHT, PEN and OHEL are latched when the start bit is detected. Changes during a frame affect the next frame only.
- FSM states and transitions:
  - IDLE -> START on a synchronised 1->0 transition of RX.
  - START: sample at the half-bit point. RX = 1 -> IDLE (false start, no push). RX = 0 -> DATA, counter reloaded.
  - DATA: sample every full bit period, LSB first. 7 or 8 bits, then PARITY if PEN else STOP.
  - PARITY: sample one bit. perr = 1 if (XOR of data bits XOR parity bit) != OHEL.
  - STOP: sample one bit; ferr = (sample == 0). Push {ferr, perr, data} the cycle after the sample, then -> IDLE.
- Re-arm: IDLE accepts a new start edge only after RX has been seen high. A stuck-low line yields at most one frame.
- FIFO timing:
  - No fall-through: a push into an empty FIFO raises rx_valid on the following cycle.
  - Pop updates the head on the next edge.
  - Push and pop in the same cycle: both take effect, count unchanged, including when the FIFO is full.
- Overrun: push while full with no simultaneous pop drops the new word, keeps FIFO contents, and sets ovf.
  - ovf clears on ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A frame whose data, parity and stop samples are all 0 is a break.
  - No FIFO push; output brk (1 bit, reset 0) pulses high for one cycle.
  - FSM waits for RX high before returning to IDLE.
- Undefined:
  - A break is pushed as data 0x00 with ferr = 1 (perr per the normal rule); port brk is absent.

Decomposition:
- Package uart_pkg:
  - Baud rate table and divisor function of CLK_HZ.
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - FIFO word layout constant (10 bits: ferr, perr, data[7:0]).
- Sub-module sync_fifo:
  - Parametrised width and depth.
  - Push/pop, full/empty and count outputs.
  - Simultaneous push/pop-when-full rule implemented there.

Test Plan:
- 115200/8N1: baud_value 8, EIGHT 1, PEN 0; send 0xA5 -> rx_data 0xA5, perr 0, ferr 0; rx_valid high 1 cycle after the stop sample (~868 clk/bit).
- 7O1: EIGHT 0, PEN 1, OHEL 1; send 0x41 with a correct parity bit, then with an inverted parity bit -> 0x41/perr 0, then 0x41/perr 1.
- False start: RX low for 300 clocks at 115200 -> no push, FSM returns to IDLE, fifo_count stays 0.
- Framing error: stop bit driven 0 with data 0x3C -> rx_data 0x3C, ferr 1.
- Overrun: FIFO_DEPTH 4, rx_ready 0; send 5 bytes -> count 4, ovf 1, head = byte 1. Pop one while the 6th byte pushes -> count stays 4. ovf_clr -> ovf 0.
- Reset mid-frame: assert reset during DATA bit 3 -> no push, all outputs at reset values; the next full frame is received correctly.
